// File: rtl/branch_predictor_pkg.sv
// Package: branch_predictor_pkg
// Purpose: shared encodings for the fetch-stage branch predictor.
//   BP_SNT/BP_WNT/BP_WT/BP_ST : 2-bit saturating counter states
//   BP_PC_INC                 : sequential fetch increment (bytes)
package branch_predictor_pkg;

  localparam logic [1:0] BP_SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] BP_WNT = 2'b01;  // weakly not-taken
  localparam logic [1:0] BP_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] BP_ST  = 2'b11;  // strongly taken

  localparam int BP_PC_INC = 4;

endpackage

// File: rtl/branch_predictor_satcnt.sv
// Module: bp_satcnt
// Purpose: next-state logic of a 2-bit saturating up/down counter.
// Ports:
//   cnt  in  [1:0]  current counter state
//   up   in  1      1 = count towards BP_ST, 0 = count towards BP_SNT
//   next out [1:0]  counter state after one step
module bp_satcnt
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       up,
  output logic [1:0] next
);

  always_comb begin
    next = cnt;
    if (up) begin
      if (cnt != BP_ST) next = cnt + 2'd1;
    end else begin
      if (cnt != BP_SNT) next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Module: branch_predictor
// Purpose: direct-mapped BTB with per-entry 2-bit saturating counters.
//   Combinational prediction for the fetch PC, training from execute,
//   and a free-running misprediction counter.
// Ports:
//   clk, rst_n       clock / async active-low reset
//   if_pc            fetch PC to predict
//   pred_taken       predicted direction for if_pc
//   pred_target      predicted next PC (entry target or if_pc+4)
//   upd_valid        a resolved conditional branch is presented
//   upd_pc           PC of the resolved branch
//   upd_taken        resolved direction
//   upd_target       resolved target
//   upd_pred_taken   direction the branch was fetched with
//   flush            invalidate every entry at the next edge
//   mispred_cnt      resolved mispredictions since reset (wraps)
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int DATAW   = 32,
  parameter int ENTRIES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DATAW-1:0] if_pc,
  output logic             pred_taken,
  output logic [DATAW-1:0] pred_target,
  input  logic             upd_valid,
  input  logic [DATAW-1:0] upd_pc,
  input  logic             upd_taken,
  input  logic [DATAW-1:0] upd_target,
  input  logic             upd_pred_taken,
  input  logic             flush,
  output logic [31:0]      mispred_cnt
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = DATAW - IDXW - 2;

  logic [ENTRIES-1:0] r_valid;
  logic [TAGW-1:0]    r_tag    [ENTRIES];
  logic [DATAW-1:0]   r_target [ENTRIES];
  logic [1:0]         r_cnt    [ENTRIES];
  logic [31:0]        r_mispred_cnt;

  // Lookup path
  logic [IDXW-1:0] w_if_idx;
  logic [TAGW-1:0] w_if_tag;
  logic            w_if_hit;

  assign w_if_idx = if_pc[IDXW+1:2];
  assign w_if_tag = if_pc[DATAW-1:IDXW+2];
  assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

  assign pred_taken  = w_if_hit && r_cnt[w_if_idx][1];
  assign pred_target = pred_taken ? r_target[w_if_idx]
                                  : if_pc + DATAW'(BP_PC_INC);

  // Update path
  logic [IDXW-1:0] w_upd_idx;
  logic [TAGW-1:0] w_upd_tag;
  logic            w_upd_hit;
  logic [1:0]      w_cnt_next;
  logic            w_btb_wr;
  logic            w_unused_upd_lsb;

  assign w_upd_idx = upd_pc[IDXW+1:2];
  assign w_upd_tag = upd_pc[DATAW-1:IDXW+2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_unused_upd_lsb = ^upd_pc[1:0];

  // Flush takes priority over any training of the table in the same cycle.
  assign w_btb_wr = upd_valid && !flush;

  bp_satcnt u_satcnt (
    .cnt  (r_cnt[w_upd_idx]),
    .up   (upd_taken),
    .next (w_cnt_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= BP_WNT;
    end else if (flush) begin
      r_valid <= '0;
    end else if (w_btb_wr) begin
      if (w_upd_hit) begin
        r_cnt[w_upd_idx] <= w_cnt_next;
      end else if (upd_taken) begin
        r_valid[w_upd_idx] <= 1'b1;
        r_cnt[w_upd_idx]   <= BP_WT;
      end
    end
  end

  // Tag/target carry no reset. A write while rst_n is low can only land in
  // an entry whose valid bit is held clear, so it is never observed.
  always_ff @(posedge clk) begin
    if (w_btb_wr && upd_taken) begin
      r_target[w_upd_idx] <= upd_target;
      if (!w_upd_hit) r_tag[w_upd_idx] <= w_upd_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mispred_cnt <= '0;
    end else if (upd_valid && (upd_taken != upd_pred_taken)) begin
      r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic        flush;
  logic [31:0] mispred_cnt;

  branch_predictor #(.DATAW(32), .ENTRIES(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .flush          (flush),
    .mispred_cnt    (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        taken;
    logic [31:0] target;
    logic [31:0] mcnt;
  } exp_t;

  exp_t q_exp[$];
  event ev_sample;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_field(input string nm, input string fld,
                             input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", nm, fld, act, exp);
    end
  endtask

  // Monitor: pops one expectation per sample request, 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(ev_sample);
      #1;
      if (q_exp.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard: sample with empty expectation queue");
      end else begin
        e = q_exp.pop_front();
        check_field(e.name, "taken",  {31'd0, pred_taken}, {31'd0, e.taken});
        check_field(e.name, "target", pred_target, e.target);
        check_field(e.name, "mcnt",   mispred_cnt, e.mcnt);
      end
    end
  end

  // Starts and ends aligned to a negedge; samples 1 unit after the call.
  task automatic lookup(input string nm, input logic [31:0] pc,
                        input logic t, input logic [31:0] tgt,
                        input logic [31:0] mc);
    exp_t e;
    if_pc = pc;
    e.name = nm; e.taken = t; e.target = tgt; e.mcnt = mc;
    q_exp.push_back(e);
    -> ev_sample;
    #2;
    @(negedge clk);
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic t,
                         input logic [31:0] tgt, input logic p);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = t;
    upd_target = tgt; upd_pred_taken = p;
  endtask

  task automatic upd(input logic [31:0] pc, input logic t,
                     input logic [31:0] tgt, input logic p);
    set_upd(pc, t, tgt, p);
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; if_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    lookup("reset", 32'h100, 1'b0, 32'h104, 0);

    // Allocate then train down: WT -> WNT -> SNT
    upd(32'h100, 1'b1, 32'h80, 1'b0);
    lookup("alloc", 32'h100, 1'b1, 32'h80, 1);
    upd(32'h100, 1'b0, 32'h0, 1'b1);
    lookup("wt_to_wnt", 32'h100, 1'b0, 32'h104, 2);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    lookup("wnt_to_snt", 32'h100, 1'b0, 32'h104, 2);

    // Saturation at ST on index 1
    upd(32'h204, 1'b1, 32'h300, 1'b0);
    for (int i = 0; i < 5; i++) upd(32'h204, 1'b1, 32'h300, 1'b1);
    upd(32'h204, 1'b0, 32'h0, 1'b1);
    lookup("st_to_wt", 32'h204, 1'b1, 32'h300, 4);
    upd(32'h204, 1'b0, 32'h0, 1'b1);
    lookup("wt_to_wnt2", 32'h204, 1'b0, 32'h208, 5);

    // Alias on index 0: 0x140 replaces 0x100
    upd(32'h140, 1'b1, 32'hA0, 1'b0);
    lookup("alias_old_miss", 32'h100, 1'b0, 32'h104, 6);
    lookup("alias_new_hit", 32'h140, 1'b1, 32'hA0, 6);
    upd(32'h180, 1'b0, 32'h0, 1'b0);
    lookup("nt_miss_no_change", 32'h140, 1'b1, 32'hA0, 6);

    // Same-cycle lookup and update: old state seen, new state next cycle
    set_upd(32'h140, 1'b0, 32'h0, 1'b1);
    lookup("same_cycle_old", 32'h140, 1'b1, 32'hA0, 6);
    upd_valid = 1'b0;
    lookup("same_cycle_new", 32'h140, 1'b0, 32'h144, 7);

    // Flush together with an allocating update
    flush = 1'b1;
    upd(32'h208, 1'b1, 32'h500, 1'b0);
    flush = 1'b0;
    lookup("flush_no_alloc", 32'h208, 1'b0, 32'h20C, 8);
    lookup("flush_clears", 32'h140, 1'b0, 32'h144, 8);

    upd(32'h208, 1'b1, 32'h500, 1'b0);
    lookup("retrain", 32'h208, 1'b1, 32'h500, 9);

    lookup("pc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 9);

    // Async reset between edges
    #2;
    rst_n = 1'b0;
    lookup("async_reset", 32'h208, 1'b0, 32'h20C, 0);
    rst_n = 1'b1;
    lookup("post_reset", 32'h208, 1'b0, 32'h20C, 0);

    #3;
    if (q_exp.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0",
               q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
